// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants common to TX and RX.
package uart_rx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_MIN_DIV   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Register-file side of the UART receiver: baud setting, pop/clear controls, data and status.
interface uart_rx_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 32
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0] baud_divisor;
    logic             rd_en;
    logic             err_clr;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [CNT_W-1:0] rx_count;
    logic             rx_done;
    logic             frame_err;
    logic             overrun;

    modport master (
        output baud_divisor, rd_en, err_clr,
        input  rx_data, rx_valid, rx_count, rx_done, frame_err, overrun
    );

    modport slave (
        input  baud_divisor, rd_en, err_clr,
        output rx_data, rx_valid, rx_count, rx_done, frame_err, overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO for received characters; pointers carry one extra wrap bit.
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   wr_data,
    output logic [7:0]                   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);

    assign rd_data = empty ? 8'h00 : mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx_in, deframes 8N1 characters LSB first and buffers them.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx_in,
    uart_rx_if.slave bus
);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    logic rx_meta, rx_s, rx_prev;

    uart_rx_state_t            state_q;
    logic [DIV_W-1:0]          div_q;
    logic [DIV_W-1:0]          cnt_q;
    logic [BIT_W-1:0]          bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      rx_done_q, frame_err_q, overrun_q;

    logic fall_edge, div_ok, half_hit, bit_hit, stop_hit;
    logic push, pop, fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall_edge = rx_prev && !rx_s;
    assign div_ok    = bus.baud_divisor >= DIV_W'(UART_MIN_DIV);
    assign half_hit  = cnt_q == (div_q >> 1) - DIV_W'(1);
    assign bit_hit   = cnt_q == div_q - DIV_W'(1);
    assign stop_hit  = (state_q == StStop) && bit_hit;
    assign pop       = bus.rd_en && !fifo_empty;
    assign push      = stop_hit && rx_s && (!fifo_full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_done_q <= push;
            if (bus.err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            // Flag sets below come later in the block, so they win over err_clr.
            case (state_q)
                StIdle: begin
                    if (fall_edge && div_ok) begin
                        div_q   <= bus.baud_divisor;
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (half_hit) begin
                        if (rx_s) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= StData;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                StData: begin
                    if (bit_hit) begin
                        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_W'(UART_DATA_BITS - 1)) state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                StStop: begin
                    if (bit_hit) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (!rx_s)      frame_err_q <= 1'b1;
                        else if (!push) overrun_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (shift_q),
        .rd_data (bus.rx_data),
        .count   (bus.rx_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.rx_valid  = !fifo_empty;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, false start, errors, overrun, FIFO wrap and reset.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;
    logic rx_in;

    uart_rx_if #(.FIFO_DEPTH(4), .DIV_W(32)) bus ();

    uart_rx #(
        .FIFO_DEPTH(4),
        .DIV_W     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int tests = 0;
    int fails = 0;
    int last_t0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; pop_at pulses rd_en on that cycle offset, abort_at stops early.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int d,
                              input int pop_at, input int abort_at);
        logic [9:0] frame;
        frame   = {stop, data, 1'b0};
        last_t0 = cyc;
        for (int i = 0; i < 10 * d; i++) begin
            if (abort_at != 0 && i == abort_at) return;
            rx_in     = frame[i / d];
            bus.rd_en = (pop_at != 0 && i == pop_at);
            step(1);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic do_pop();
        bus.rd_en = 1'b1;
        step(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clr();
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
    endtask

    int d0;

    initial begin
        reset            = 1'b0;
        rx_in            = 1'b1;
        bus.rd_en        = 1'b0;
        bus.err_clr      = 1'b0;
        bus.baud_divisor = 32'd16;
        step(3);
        check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_count", {29'd0, bus.rx_count}, 32'd0);
        check("rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_done", {31'd0, bus.rx_done}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_ovr", {31'd0, bus.overrun}, 32'd0);
        reset = 1'b1;
        step(5);

        // Single byte; stop sample lands 2 + D/2 + 9D cycles after the start bit is driven
        d0 = done_cnt;
        send_frame(8'hA5, 1'b1, 16, 0, 0);
        check("a5_done_cnt", done_cnt, d0 + 1);
        check("a5_done_cyc", done_cyc, last_t0 + 155);
        check("a5_data", {24'd0, bus.rx_data}, 32'h0000_00A5);
        check("a5_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("a5_count", {29'd0, bus.rx_count}, 32'd1);
        do_pop();
        check("a5_pop_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("a5_pop_count", {29'd0, bus.rx_count}, 32'd0);
        do_pop();
        check("empty_pop_count", {29'd0, bus.rx_count}, 32'd0);
        check("empty_pop_valid", {31'd0, bus.rx_valid}, 32'd0);

        // Divisor below the minimum: start edges are ignored
        bus.baud_divisor = 32'd3;
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, 3, 0, 0);
        step(10);
        check("div3_done", done_cnt, d0);
        check("div3_count", {29'd0, bus.rx_count}, 32'd0);
        check("div3_ferr", {31'd0, bus.frame_err}, 32'd0);
        bus.baud_divisor = 32'd16;
        step(5);

        // False start
        rx_in = 1'b0;
        step(4);
        rx_in = 1'b1;
        step(40);
        check("false_done", done_cnt, d0);
        check("false_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("false_ovr", {31'd0, bus.overrun}, 32'd0);
        check("false_count", {29'd0, bus.rx_count}, 32'd0);

        // Framing error, then line held low must not retrigger
        send_frame(8'h3C, 1'b0, 16, 0, 0);
        check("ferr_set", {31'd0, bus.frame_err}, 32'd1);
        check("ferr_count", {29'd0, bus.rx_count}, 32'd0);
        check("ferr_done", done_cnt, d0);
        step(40);
        rx_in = 1'b1;
        step(20);
        check("low_hold_done", done_cnt, d0);
        check("low_hold_ferr", {31'd0, bus.frame_err}, 32'd1);
        do_clr();
        check("ferr_clr", {31'd0, bus.frame_err}, 32'd0);
        step(5);

        // Overrun with back-to-back frames, ordered pops, then wrap
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 16, 0, 0);
        check("ovr_set", {31'd0, bus.overrun}, 32'd1);
        check("ovr_count", {29'd0, bus.rx_count}, 32'd4);
        check("ovr_done", done_cnt, d0 + 4);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_pop_data", {24'd0, bus.rx_data}, k);
            do_pop();
        end
        check("ovr_drain_valid", {31'd0, bus.rx_valid}, 32'd0);
        send_frame(8'h06, 1'b1, 16, 0, 0);
        check("wrap_data", {24'd0, bus.rx_data}, 32'h0000_0006);
        check("wrap_count", {29'd0, bus.rx_count}, 32'd1);
        do_pop();
        do_clr();
        check("ovr_clr", {31'd0, bus.overrun}, 32'd0);
        step(5);

        // Full FIFO with a pop in the stop-sample cycle
        for (int b = 16; b <= 19; b++) send_frame(8'(b), 1'b1, 16, 0, 0);
        d0 = done_cnt;
        send_frame(8'h14, 1'b1, 16, 154, 0);
        check("pp_ovr", {31'd0, bus.overrun}, 32'd0);
        check("pp_count", {29'd0, bus.rx_count}, 32'd4);
        check("pp_done", done_cnt, d0 + 1);
        for (int k = 17; k <= 20; k++) begin
            check("pp_pop_data", {24'd0, bus.rx_data}, k);
            do_pop();
        end
        check("pp_drain_count", {29'd0, bus.rx_count}, 32'd0);
        step(5);

        // Reset in the middle of data bit 3, with a byte buffered and an error pending
        send_frame(8'h77, 1'b1, 16, 0, 0);
        send_frame(8'h00, 1'b0, 16, 0, 0);
        rx_in = 1'b1;
        step(5);
        check("pre_rst_ferr", {31'd0, bus.frame_err}, 32'd1);
        send_frame(8'h5A, 1'b1, 16, 0, 70);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("mid_rst_count", {29'd0, bus.rx_count}, 32'd0);
        check("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("mid_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("mid_rst_done", {31'd0, bus.rx_done}, 32'd0);
        rx_in = 1'b1;
        step(3);
        reset = 1'b1;
        step(5);
        d0 = done_cnt;
        send_frame(8'h5A, 1'b1, 16, 0, 0);
        check("post_rst_data", {24'd0, bus.rx_data}, 32'h0000_005A);
        check("post_rst_count", {29'd0, bus.rx_count}, 32'd1);
        check("post_rst_done", done_cnt, d0 + 1);
        check("post_rst_ferr", {31'd0, bus.frame_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the SoC UART: oversamples the serial input, deframes 8N1 characters (LSB first) and buffers them in a small show-ahead FIFO. The UART register file reads the buffer through a pop handshake and reports status. Bit timing uses the same cycles-per-bit divisor written by software for the transmitter, so TX and RX share one baud setting.

## Interface
- `FIFO_DEPTH`, default 4: receive buffer entries; must be a power of two and at least 2.
- `DIV_W`, default 32: width of the baud divisor.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `rx_in` input, 1 bit: serial line. Asynchronous to `clk`; idles high.
- `baud_divisor` input, `DIV_W` bits: clock cycles per bit.
- `rd_en` input, 1 bit: pop the head byte.
- `err_clr` input, 1 bit: clear the sticky error flags.
- `rx_data` output, 8 bits: head byte of the FIFO (show-ahead).
- `rx_valid` output, 1 bit: FIFO not empty.
- `rx_count` output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
- `rx_done` output, 1 bit: one-cycle pulse when a byte is pushed into the FIFO.
- `frame_err` output, 1 bit: sticky; stop bit was sampled low.
- `overrun` output, 1 bit: sticky; a byte arrived while the FIFO was full.

## Operation
- **Synchronizer.** `rx_in` passes through a 2-flop synchronizer, reset value 1. A third flop `rx_prev` is used for falling-edge detection. All decisions use the synchronized signal `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE.**
  - The receiver waits for a falling edge (`rx_prev`=1 and `rx_s`=0).
  - On that edge it latches `baud_divisor` into `div_q`, clears the cycle counter and moves to START.
  - A line held low never retriggers, because an edge is required.
  - If `baud_divisor` < 4, the falling edge is ignored and the FSM stays in IDLE.
- **START.**
  - At counter = (`div_q`>>1)−1, the receiver samples the line.
  - If the sample is 1, the edge was a false start: return to IDLE with no flags set.
  - If the sample is 0, clear the counter and the bit index and go to DATA.
- **DATA.**
  - At counter = `div_q`−1, sample the line into the shift register, LSB first.
  - The counter clears and the bit index increments.
  - After bit index 7 is sampled, go to STOP.
- **STOP.** At counter = `div_q`−1, sample the line, then return to IDLE in every case.
  - Sample = 1 and the FIFO is not full (or a pop occurs in the same cycle): push the byte and pulse `rx_done`.
  - Sample = 1 and the FIFO is full with no pop: drop the byte and set `overrun`. No `rx_done` pulse.
  - Sample = 0: discard the byte and set `frame_err`. The FIFO is unchanged.
- **Divisor changes.** A `baud_divisor` change during a frame has no effect until the next start edge.
- **FIFO.**
  - Circular buffer with pointers one bit wider than the index; full/empty are derived from the pointers.
  - `rd_en` while empty is ignored; pointers do not move.
  - Simultaneous push and pop: both take effect and `rx_count` is unchanged, including when full.
  - Pointers wrap modulo 2·`FIFO_DEPTH`.
- **Sticky flags.**
  - `err_clr` clears `frame_err` and `overrun`.
  - If a set condition and `err_clr` occur in the same cycle, set wins.

## Timing
- **Reset.** Assertion of `reset` acts immediately, including mid-frame. After reset:
  - FSM in IDLE, all counters 0, synchronizer flops 1.
  - FIFO empty: `rx_valid`=0, `rx_count`=0, `rx_data`=0.
  - `rx_done`=0, `frame_err`=0, `overrun`=0.
- **Input latency.** 2 cycles from a `rx_in` change to `rx_s`.
- **Sample points** (with D = `div_q`, E = the cycle the falling edge is detected):
  - Start bit at E + D/2.
  - Data bit k at E + D/2 + (k+1)·D.
  - Stop bit at E + D/2 + 9·D.
- **Output latency.**
  - `rx_done`, `rx_valid` and the updated `rx_data`/`rx_count` appear in the cycle after the stop sample.
  - A pop updates `rx_data`/`rx_count` in the next cycle.
- **Back-to-back frames.** A new start edge is accepted in the first cycle after returning to IDLE, so frames with no idle gap between them are received.

## Structure
- The shared package holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP);
  - the constants `UART_DATA_BITS` = 8 and `UART_MIN_DIV` = 4, shared with the transmitter.
- One sub-module, `uart_rx_fifo`: parameterized `FIFO_DEPTH` × 8 buffer with push/pop/count/full/empty.
- The FSM, counter, synchronizer and flags stay in `uart_rx`.

## Test plan
- **Single byte:** `baud_divisor`=16, send 0xA5 framed 8N1 → one `rx_done` pulse at stop-sample+1; `rx_data`=0xA5, `rx_valid`=1, `rx_count`=1; pop → `rx_valid`=0.
- **False start:** `baud_divisor`=16, `rx_in` low for 4 cycles then high → FSM returns to IDLE, no `rx_done`, no flags.
- **Framing error:** send 0x3C with the stop bit low → `frame_err`=1, `rx_count`=0; line held low for 40 cycles causes no retrigger; `err_clr` → `frame_err`=0.
- **Overrun and wrap:** `FIFO_DEPTH`=4, send 0x01..0x05 with no pops → `overrun`=1, `rx_count`=4; pops return 0x01..0x04 in order; then send and pop 0x06 → correct after pointer wrap.
- **Simultaneous push/pop when full:** assert `rd_en` in the stop-sample cycle → no overrun, `rx_count` stays 4, head advances.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → all outputs at reset values; the next clean frame 0x5A is received correctly.
